lvds_deser_align: RTL and testbench

- Multi-lane serial-to-parallel deserializer with automatic word alignment.
- Each lane shifts in one bit per lvds_clk and searches for a fixed training word to find the word boundary, then locks.
- Once locked, each lane delivers aligned parallel words on a common word strobe.
- Sits directly behind the LVDS input pins and feeds the downstream parallel video/data path.

---
 rtl/lvds_deser_pkg.sv | 29 ++
 rtl/lvds_deser_align_lane.sv | 121 ++++++++++++
 rtl/lvds_deser_align.sv | 73 +++++++
 tb/tb_lvds_deser_align.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_deser_pkg.sv
// Shared types and helpers for the multi-lane LVDS deserializer and word aligner.
package lvds_deser_pkg;

    // Per-lane alignment state.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lane_state_t;

    // Widest word the bit-reverse helper handles.
    localparam int MAX_W = 64;

    // Width of a bit-offset / word-position counter for a given word width.
    function automatic int ofs_w(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

    // Reverse the low 'width' bits of v; bits above 'width' come back as 0.
    function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] v, input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r[i] = v[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/lvds_deser_align_lane.sv
// One serial lane: shift register, offset-selected word window, and the
// SEARCH / VERIFY / LOCKED alignment state machine with its counters.
module lvds_lane_align
    import lvds_deser_pkg::*;
#(
    parameter int                WORD_W    = 8,
    parameter logic [WORD_W-1:0] TRAIN_PAT = 8'h5C,
    parameter int                LOCK_CNT  = 4,
    parameter int                ERR_MAX   = 2,
    parameter int                MSB_FIRST = 1,
    localparam int               OFS_W     = ofs_w(WORD_W)
) (
    input  logic              lvds_clk,
    input  logic              rst,
    input  logic              lvds_d,
    input  logic              word_stb,
    input  logic              train_en,
    output logic [WORD_W-1:0] o_data,
    output logic              o_locked,
    output logic [OFS_W-1:0]  o_offset
);

    localparam int SR_W = 2 * WORD_W - 1;
    localparam int CW   = $clog2(LOCK_CNT + 1);
    localparam int EW   = $clog2(ERR_MAX + 1);

    logic [SR_W-1:0]   sr;
    lane_state_t       state;
    logic [CW-1:0]     match_cnt;
    logic [EW-1:0]     err_cnt;
    logic [WORD_W-1:0] win_raw;
    logic [WORD_W-1:0] win;
    logic              match;
    logic [OFS_W-1:0]  ofs_inc;

    // Bit history: newest bit enters at bit 0, older bits move up.
    // NOTE: the history is reset as well, so a restart never matches against bits left over from before reset.
    always_ff @(posedge lvds_clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            // NOTE: non-blocking so the window below always sees the pre-edge history.
            sr <= {sr[SR_W-2:0], lvds_d};
        end
    end

    // Window at the selected offset; larger offsets reach older bits.
    assign win_raw = sr[o_offset +: WORD_W];
    assign win     = (MSB_FIRST != 0) ? win_raw
                                      : WORD_W'(bit_rev(MAX_W'(win_raw), WORD_W));
    assign match   = (win == TRAIN_PAT);
    assign ofs_inc = (o_offset == OFS_W'(WORD_W - 1)) ? '0 : o_offset + OFS_W'(1);

    // Alignment FSM and word capture, all evaluated on the word strobe.
    always_ff @(posedge lvds_clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            o_offset  <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
            o_locked  <= 1'b0;
            o_data    <= '0;
        end else if (word_stb) begin
            o_data <= win;
            if (train_en) begin
                case (state)
                    SEARCH: begin
                        if (match) begin
                            if (LOCK_CNT == 1) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                            end else begin
                                state     <= VERIFY;
                                match_cnt <= CW'(1);
                            end
                        end else begin
                            o_offset <= ofs_inc;
                        end
                    end
                    VERIFY: begin
                        if (match) begin
                            if (match_cnt == CW'(LOCK_CNT - 1)) begin
                                state     <= LOCKED;
                                o_locked  <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + CW'(1);
                            end
                        end else begin
                            state     <= SEARCH;
                            o_offset  <= ofs_inc;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            err_cnt <= '0;
                        end else if (err_cnt == EW'(ERR_MAX - 1)) begin
                            state    <= SEARCH;
                            o_locked <= 1'b0;
                            o_offset <= ofs_inc;
                            err_cnt  <= '0;
                        end else begin
                            err_cnt <= err_cnt + EW'(1);
                        end
                    end
                    default: begin
                        state     <= SEARCH;
                        o_locked  <= 1'b0;
                        match_cnt <= '0;
                        err_cnt   <= '0;
                    end
                endcase
            end else begin
                // Without training traffic there is nothing to check against.
                err_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lvds_deser_align.sv
// Multi-lane LVDS deserializer with per-lane automatic word alignment.
// Holds the shared word counter and the all-lanes valid / lock outputs.
module lvds_deser_align
    import lvds_deser_pkg::*;
#(
    parameter int                LANES     = 4,
    parameter int                WORD_W    = 8,
    parameter logic [WORD_W-1:0] TRAIN_PAT = 8'h5C,
    parameter int                LOCK_CNT  = 4,
    parameter int                ERR_MAX   = 2,
    parameter int                MSB_FIRST = 1
) (
    input  logic                                lvds_clk,
    input  logic                                rst,
    input  logic [LANES-1:0]                    lvds_d,
    input  logic                                train_en,
    output logic [LANES*WORD_W-1:0]             o_data,
    output logic                                o_valid,
    output logic [LANES-1:0]                    o_locked,
    output logic                                o_all_locked,
    output logic [LANES*$clog2(WORD_W)-1:0]     o_offset
);

    localparam int OFS_W = ofs_w(WORD_W);

    logic [OFS_W-1:0] cnt;
    logic             word_stb;
    logic             stb_q;

    assign word_stb = (cnt == OFS_W'(WORD_W - 1));

    // Free-running word position counter shared by all lanes.
    always_ff @(posedge lvds_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= word_stb ? '0 : cnt + OFS_W'(1);
        end
    end

    // Marks the cycle right after a strobe edge, when lane outputs are fresh.
    always_ff @(posedge lvds_clk or posedge rst) begin
        if (rst) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= word_stb;
        end
    end

    // Both terms are flops, so valid reflects the lock state after the strobe edge.
    assign o_all_locked = &o_locked;
    assign o_valid      = stb_q & o_all_locked;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lvds_lane_align #(
            .WORD_W    (WORD_W),
            .TRAIN_PAT (TRAIN_PAT),
            .LOCK_CNT  (LOCK_CNT),
            .ERR_MAX   (ERR_MAX),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane (
            .lvds_clk (lvds_clk),
            .rst      (rst),
            .lvds_d   (lvds_d[i]),
            .word_stb (word_stb),
            .train_en (train_en),
            .o_data   (o_data[i*WORD_W +: WORD_W]),
            .o_locked (o_locked[i]),
            .o_offset (o_offset[i*OFS_W +: OFS_W])
        );
    end

endmodule

// File: tb/tb_lvds_deser_align.sv
// Bench for lvds_deser_align: an MSB-first and an LSB-first instance, driven
// with per-lane word streams and checked every cycle against a model built
// from a per-lane bit history and the alignment rules.
module tb_lvds_deser_align;

    localparam int W    = 8;
    localparam int NL   = 8;   // lanes 0..3: MSB-first DUT, lanes 4..7: LSB-first DUT
    localparam int HLEN = 64;
    localparam logic [7:0] TP = 8'h5C;
    localparam int LOCK_N = 4;
    localparam int ERR_N  = 2;

    logic        lvds_clk = 1'b0;
    logic        rst      = 1'b0;
    logic        train_en = 1'b0;
    logic [3:0]  lvds_d   = '0;
    logic [3:0]  lvds_d2  = '0;
    logic [31:0] o_data,   o_data2;
    logic        o_valid,  o_valid2;
    logic [3:0]  o_locked, o_locked2;
    logic        o_all_locked, o_all_locked2;
    logic [11:0] o_offset, o_offset2;

    always #5 lvds_clk = ~lvds_clk;

    lvds_deser_align #(.MSB_FIRST(1)) dut (
        .lvds_clk(lvds_clk), .rst(rst), .lvds_d(lvds_d), .train_en(train_en),
        .o_data(o_data), .o_valid(o_valid), .o_locked(o_locked),
        .o_all_locked(o_all_locked), .o_offset(o_offset));

    lvds_deser_align #(.MSB_FIRST(0)) dut_lsb (
        .lvds_clk(lvds_clk), .rst(rst), .lvds_d(lvds_d2), .train_en(train_en),
        .o_data(o_data2), .o_valid(o_valid2), .o_locked(o_locked2),
        .o_all_locked(o_all_locked2), .o_offset(o_offset2));

    // Stimulus state: 0 = training word, 1 = random words, 2 = fixed word.
    int         mode[NL];
    int         skew[NL];
    int         slot[NL];
    int         bad_from[NL];
    int         bad_num[NL];
    logic [7:0] bad_word[NL];
    logic [7:0] fixw[NL];
    logic [7:0] cur_word[NL];
    int         nc;
    int         vcount;

    // Reference model state.
    bit         hist[NL][HLEN];
    int         nsr;
    int         m_cnt;
    int         m_st[NL];   // 0 search, 1 verify, 2 locked
    int         m_mc[NL];
    int         m_ec[NL];
    int         m_off[NL];
    logic [7:0] m_data[NL];
    logic       m_valid[2];

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] pick_word(int l);
        if (mode[l] == 0) begin
            if (slot[l] >= bad_from[l] && slot[l] < bad_from[l] + bad_num[l]) return bad_word[l];
            return TP;
        end
        if (mode[l] == 1) return 8'($urandom);
        return fixw[l];
    endfunction

    function automatic logic [7:0] rand_bad();
        logic [7:0] w;
        w = 8'($urandom);
        if (w == TP) w = 8'hA3;
        return w;
    endfunction

    // Bit sampled 'a' edges ago (0 = newest); nothing before reset counts as 0.
    function automatic bit age_bit(int l, int a);
        if (a >= nsr) return 1'b0;
        return hist[l][(nsr - 1 - a) % HLEN];
    endfunction

    // Word whose newest bit is 'k' edges old, in transmit order of the lane's DUT.
    function automatic logic [7:0] window(int l, int k);
        logic [7:0] w;
        for (int j = 0; j < W; j++) begin
            if (l < 4) w[j] = age_bit(l, k + j);
            else       w[W-1-j] = age_bit(l, k + j);
        end
        return w;
    endfunction

    task automatic model_reset();
        nsr   = 0;
        m_cnt = 0;
        for (int l = 0; l < NL; l++) begin
            m_st[l] = 0; m_mc[l] = 0; m_ec[l] = 0; m_off[l] = 0; m_data[l] = '0;
        end
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
    endtask

    task automatic model_edge(input logic [NL-1:0] b, input logic te);
        logic [7:0] w;
        bit         hit;
        if (m_cnt == W - 1) begin
            for (int l = 0; l < NL; l++) begin
                w = window(l, m_off[l]);
                m_data[l] = w;
                hit = (w == TP);
                if (te) begin
                    if (m_st[l] == 0) begin
                        if (hit) begin
                            m_st[l] = (LOCK_N == 1) ? 2 : 1;
                            m_mc[l] = 1;
                        end else m_off[l] = (m_off[l] + 1) % W;
                    end else if (m_st[l] == 1) begin
                        if (hit) begin
                            m_mc[l]++;
                            if (m_mc[l] == LOCK_N) m_st[l] = 2;
                        end else begin
                            m_st[l] = 0; m_mc[l] = 0; m_off[l] = (m_off[l] + 1) % W;
                        end
                    end else begin
                        if (hit) m_ec[l] = 0;
                        else begin
                            m_ec[l]++;
                            if (m_ec[l] == ERR_N) begin
                                m_st[l] = 0; m_ec[l] = 0; m_off[l] = (m_off[l] + 1) % W;
                            end
                        end
                    end
                end else begin
                    m_ec[l] = 0;
                end
            end
            for (int d = 0; d < 2; d++) begin
                m_valid[d] = 1'b1;
                for (int l = 0; l < 4; l++) if (m_st[d*4+l] != 2) m_valid[d] = 1'b0;
            end
        end else begin
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
        end
        for (int l = 0; l < NL; l++) hist[l][nsr % HLEN] = b[l];
        nsr++;
        m_cnt = (m_cnt + 1) % W;
    endtask

    function automatic logic [31:0] exp_data(int d);
        logic [31:0] v;
        for (int l = 0; l < 4; l++) v[l*8 +: 8] = m_data[d*4+l];
        return v;
    endfunction

    function automatic logic [3:0] exp_locked(int d);
        logic [3:0] v;
        for (int l = 0; l < 4; l++) v[l] = (m_st[d*4+l] == 2);
        return v;
    endfunction

    function automatic logic [11:0] exp_off(int d);
        logic [11:0] v;
        for (int l = 0; l < 4; l++) v[l*3 +: 3] = 3'(m_off[d*4+l]);
        return v;
    endfunction

    task automatic compare_all();
        logic [3:0] lk0, lk1;
        lk0 = exp_locked(0);
        lk1 = exp_locked(1);
        chk("data",           o_data,               exp_data(0));
        chk("valid",          32'(o_valid),         32'(m_valid[0]));
        chk("locked",         32'(o_locked),        32'(lk0));
        chk("all_locked",     32'(o_all_locked),    32'(&lk0));
        chk("offset",         32'(o_offset),        32'(exp_off(0)));
        chk("lsb_data",       o_data2,              exp_data(1));
        chk("lsb_valid",      32'(o_valid2),        32'(m_valid[1]));
        chk("lsb_locked",     32'(o_locked2),       32'(lk1));
        chk("lsb_all_locked", 32'(o_all_locked2),   32'(&lk1));
        chk("lsb_offset",     32'(o_offset2),       32'(exp_off(1)));
    endtask

    // One bit period: drive at the falling edge, model and compare after the rising edge.
    task automatic cycle();
        logic [NL-1:0] b;
        int p;
        for (int l = 0; l < NL; l++) begin
            p = (nc + 1 + skew[l]) % W;
            if (p == 0) begin
                slot[l]++;
                cur_word[l] = pick_word(l);
            end
            b[l] = (l < 4) ? cur_word[l][W-1-p] : cur_word[l][p];
        end
        lvds_d  = b[3:0];
        lvds_d2 = b[7:4];
        @(posedge lvds_clk);
        model_edge(b, train_en);
        nc++;
        #1;
        compare_all();
        if (o_valid) vcount++;
        @(negedge lvds_clk);
    endtask

    task automatic run_words(input int k);
        repeat (k * W) cycle();
    endtask

    task automatic start_stream();
        nc = 0;
        for (int l = 0; l < NL; l++) begin
            slot[l] = 0;
            cur_word[l] = pick_word(l);
        end
    endtask

    task automatic set_modes(input int m);
        for (int l = 0; l < NL; l++) begin
            mode[l] = m; skew[l] = 0; bad_num[l] = 0; bad_from[l] = 0;
            bad_word[l] = 8'hFF; fixw[l] = 8'h00;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"},   o_data,               32'h0);
        chk({tag, "_valid"},  32'(o_valid),         32'h0);
        chk({tag, "_locked"}, 32'(o_locked),        32'h0);
        chk({tag, "_offset"}, 32'(o_offset),        32'h0);
        chk({tag, "_lsb"},    32'(o_locked2) | 32'(o_offset2) | o_data2 | 32'(o_valid2), 32'h0);
    endtask

    // Asynchronous reset in the middle of the low clock phase, held, released at a falling edge.
    task automatic do_reset();
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        model_reset();
        repeat (2) @(posedge lvds_clk);
        #1;
        check_zero("rst_hold");
        @(negedge lvds_clk);
        rst = 1'b0;
        start_stream();
    endtask

    initial begin
        set_modes(1);
        model_reset();
        train_en = 1'b1;
        #1 rst = 1'b1;
        #1 check_zero("rst_init");
        @(negedge lvds_clk);
        rst = 1'b0;
        start_stream();

        // Random traffic, then reset mid-stream.
        repeat ($urandom_range(20, 40)) cycle();
        set_modes(0);
        do_reset();

        // Aligned lock on all lanes.
        run_words(8);
        chk("a_locked",     32'(o_locked),  32'hF);
        chk("a_lsb_locked", 32'(o_locked2), 32'hF);
        chk("a_offset",     32'(o_offset),  32'h0);
        vcount = 0;
        run_words(3);
        chk("a_valid_cnt",  32'(vcount),    32'd3);
        chk("a_data",       o_data,         32'h5C5C5C5C);
        chk("a_lsb_data",   o_data2,        32'h5C5C5C5C);

        // Lane 2 skewed by three bits.
        set_modes(0);
        skew[2] = 3; skew[6] = 3;
        do_reset();
        run_words(10);
        chk("b_offset",     32'(o_offset),  32'h0C0);
        chk("b_lsb_offset", 32'(o_offset2), 32'h0C0);
        chk("b_locked",     32'(o_all_locked & o_all_locked2), 32'h1);

        // Third training word corrupted on lane 0 while verifying.
        set_modes(0);
        bad_from[0] = 2; bad_num[0] = 1;
        bad_from[4] = 2; bad_num[4] = 1;
        do_reset();
        run_words(3);
        chk("c_drop",       32'(o_locked[0]),  32'h0);
        chk("c_off1",       32'(o_offset[2:0]), 32'h1);
        run_words(15);
        chk("c_relock",     32'(o_locked & o_locked2), 32'hF);
        chk("c_offset",     32'(o_offset | o_offset2), 32'h0);

        // One bad word while locked: lock holds.
        bad_word[0] = rand_bad(); bad_word[4] = bad_word[0];
        bad_from[0] = slot[0] + 1; bad_num[0] = 1;
        bad_from[4] = slot[4] + 1; bad_num[4] = 1;
        run_words(2);
        chk("d1_locked",    32'(o_locked & o_locked2), 32'hF);
        chk("d1_valid",     32'(o_valid & o_valid2),   32'h1);

        // Two consecutive bad words: lock drops on the second, valid suppressed.
        bad_word[0] = rand_bad(); bad_word[4] = bad_word[0];
        bad_from[0] = slot[0] + 1; bad_num[0] = 2;
        bad_from[4] = slot[4] + 1; bad_num[4] = 2;
        run_words(2);
        chk("d2_first",     32'(o_locked & o_locked2), 32'hF);
        run_words(1);
        chk("d2_locked",    32'(o_locked),  32'hE);
        chk("d2_lsb_lock",  32'(o_locked2), 32'hE);
        chk("d2_valid",     32'(o_valid | o_valid2), 32'h0);
        run_words(14);
        chk("d2_relock",    32'(o_locked & o_locked2), 32'hF);

        // Training off, arbitrary data: lock is kept.
        train_en = 1'b0;
        for (int l = 0; l < NL; l++) mode[l] = 1;
        run_words(6);
        chk("e_locked",     32'(o_locked & o_locked2), 32'hF);

        // Payload word 8'hA1 through both bit orders.
        for (int l = 0; l < NL; l++) begin
            mode[l] = 2; fixw[l] = 8'hA1;
        end
        run_words(3);
        chk("f_data",       o_data,         32'hA1A1A1A1);
        chk("f_lsb_data",   o_data2,        32'hA1A1A1A1);
        chk("f_valid",      32'(o_valid & o_valid2), 32'h1);

        // Reset while locked clears everything.
        do_reset();
        run_words(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
